// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and sizing helpers for the parametrised scratch RAM.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Number of ignored low address bits for a bus of the given width.
  function automatic int byte_off_width(input int data_width);
    return clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_lite_ram_pl_if.sv
// AXI4-Lite bus bundle between an interconnect master port and the scratch RAM slave.
interface axi4_lite_ram_pl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_ram_core.sv
// Simple dual-port RAM: byte-enabled write port and a registered, read-first read port.
module axi4_lite_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_AW     = 8
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [MEM_AW-1:0]       wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [MEM_AW-1:0]       rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // NOTE: no reset here -- a resettable array cannot map onto block RAM, and the
    // read register is only observed once the top-level valid pipeline says so.
    // NOTE: non-blocking assignments make a same-edge read return the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_idx];
    end
endmodule

// File: rtl/axi4_lite_ram_pl.sv
// AXI4-Lite slave RAM: independent AW/W capture, byte strobes, READ_LATENCY-deep read
// pipeline and SLVERR for word indices beyond MEM_DEPTH.
module axi4_lite_ram_pl
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int MEM_DEPTH    = 256,
    parameter int READ_LATENCY = 2
) (
    input logic               ACLK,
    input logic               ARESET,
    axi4_lite_ram_pl_if.slave bus
);
    localparam int OFF_W  = byte_off_width(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W:0]          DEPTH_X = (IDX_W + 1)'(MEM_DEPTH);
    localparam logic [READ_LATENCY-1:0] VLD_LSB = 1;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic out_of_range(input idx_t idx);
        return {1'b0, idx} >= DEPTH_X;
    endfunction

    logic                    aw_ready_q, aw_ready_n, w_ready_q, w_ready_n;
    logic                    aw_held_q, aw_held_n, w_held_q, w_held_n;
    logic                    b_valid_q, b_valid_n;
    logic [1:0]              b_resp_q, b_resp_n;
    idx_t                    aw_idx_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic                    aw_hs, w_hs, b_hs, commit, aw_oor;

    logic                    ar_ready_q, ar_ready_n, ar_pend_q, ar_pend_n, ar_oor_q;
    idx_t                    ar_idx_q;
    logic [READ_LATENCY-1:0] vld_q, vld_n, oor_q, oor_n;
    logic                    ar_hs, r_hs;
    logic [DATA_WIDTH-1:0]   core_rd_data, rd_last;
    logic                    unused_lo;

    assign aw_hs  = bus.AWVALID & aw_ready_q;
    assign w_hs   = bus.WVALID & w_ready_q;
    assign b_hs   = b_valid_q & bus.BREADY;
    assign commit = aw_held_q & w_held_q & ~b_valid_q;
    assign aw_oor = out_of_range(aw_idx_q);
    assign ar_hs  = bus.ARVALID & ar_ready_q;
    assign r_hs   = vld_q[READ_LATENCY-1] & bus.RREADY;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned.
    always_comb begin
        aw_held_n = aw_held_q | aw_hs;
        w_held_n  = w_held_q | w_hs;
        b_valid_n = b_valid_q;
        b_resp_n  = b_resp_q;
        if (commit) begin
            b_valid_n = 1'b1;
            b_resp_n  = aw_oor ? RESP_SLVERR : RESP_OKAY;
        end
        if (b_hs) begin
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            b_valid_n = 1'b0;
        end
        aw_ready_n = ~aw_held_n & ~b_valid_n;
        w_ready_n  = ~w_held_n & ~b_valid_n;

        ar_pend_n = ar_hs;
        vld_n     = (vld_q << 1) | (ar_pend_q ? VLD_LSB : '0);
        oor_n     = (oor_q << 1) | (ar_oor_q ? VLD_LSB : '0);
        // The output stage holds its beat until the master takes it.
        if (vld_q[READ_LATENCY-1] & ~r_hs) begin
            vld_n[READ_LATENCY-1] = 1'b1;
            oor_n[READ_LATENCY-1] = oor_q[READ_LATENCY-1];
        end
        ar_ready_n = ~ar_pend_n & ~(|vld_n);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            ar_ready_q <= 1'b0;
            ar_pend_q  <= 1'b0;
            vld_q      <= '0;
            oor_q      <= '0;
        end else begin
            aw_ready_q <= aw_ready_n;
            w_ready_q  <= w_ready_n;
            aw_held_q  <= aw_held_n;
            w_held_q   <= w_held_n;
            b_valid_q  <= b_valid_n;
            b_resp_q   <= b_resp_n;
            ar_ready_q <= ar_ready_n;
            ar_pend_q  <= ar_pend_n;
            vld_q      <= vld_n;
            oor_q      <= oor_n;
        end
    end

    // Payload registers are qualified by the flags above and need no reset.
    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_idx_q <= bus.AWADDR[ADDR_WIDTH-1:OFF_W];
        if (w_hs) begin
            w_data_q <= bus.WDATA;
            w_strb_q <= bus.WSTRB;
        end
        if (ar_hs) begin
            ar_idx_q <= bus.ARADDR[ADDR_WIDTH-1:OFF_W];
            ar_oor_q <= out_of_range(bus.ARADDR[ADDR_WIDTH-1:OFF_W]);
        end
    end

    axi4_lite_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .MEM_AW     (MEM_AW)
    ) u_core (
        .clk     (ACLK),
        .wr_en   (commit & ~aw_oor),
        .wr_idx  (aw_idx_q[MEM_AW-1:0]),
        .wr_data (w_data_q),
        .wr_strb (w_strb_q),
        .rd_en   (ar_pend_q & ~ar_oor_q),
        .rd_idx  (ar_idx_q[MEM_AW-1:0]),
        .rd_data (core_rd_data)
    );

    if (READ_LATENCY == 1) begin : g_no_stages
        assign rd_last = core_rd_data;
    end else begin : g_stages
        logic [DATA_WIDTH-1:0] stage_q [READ_LATENCY-1];
        always_ff @(posedge ACLK) begin
            if (vld_q[0]) stage_q[0] <= core_rd_data;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
                if (vld_q[k]) stage_q[k] <= stage_q[k-1];
            end
        end
        assign rd_last = stage_q[READ_LATENCY-2];
    end

    assign bus.AWREADY = aw_ready_q;
    assign bus.WREADY  = w_ready_q;
    assign bus.BVALID  = b_valid_q;
    assign bus.BRESP   = b_resp_q;
    assign bus.ARREADY = ar_ready_q;
    assign bus.RVALID  = vld_q[READ_LATENCY-1];
    assign bus.RRESP   = (vld_q[READ_LATENCY-1] & oor_q[READ_LATENCY-1]) ? RESP_SLVERR : RESP_OKAY;
    assign bus.RDATA   = (vld_q[READ_LATENCY-1] & ~oor_q[READ_LATENCY-1]) ? rd_last : '0;

    assign unused_lo = ^{bus.AWADDR[OFF_W-1:0], bus.ARADDR[OFF_W-1:0]};
endmodule
